config_write_arbiter: RTL and testbench
=======================================

CONFIG_WRITE_ARBITER -- requirements
Module: config_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2; number of config-write requesters, 1..8.
REQ-002 Parameter ADDR_BITS, default 8; config address width.
REQ-003 Parameter DATA_BITS, default 64; config data width.
REQ-004 Parameter MAX_BURST, default 16; maximum writes per lock tenure, 1..256.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester write request.
REQ-008 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-009 req_addr  in  NUM_REQ*ADDR_BITS  per-requester address, requester i at slice i.
REQ-010 req_data  in  NUM_REQ*DATA_BITS  per-requester data, requester i at slice i.
REQ-011 req_last  in  NUM_REQ  marks final write of a locked burst.
REQ-012 out_valid  out  1  config write strobe to the config splitter.
REQ-013 out_addr  out  ADDR_BITS  config write address.
REQ-014 out_data  out  DATA_BITS  config write data.
REQ-015 out_owner  out  $clog2(NUM_REQ) (min 1)  index of the requester that issued the current out write.
REQ-016 busy  out  1  high while state is LOCKED.

Function
REQ-017 The output bus SHALL have no backpressure; each accepted request SHALL produce exactly one out_valid pulse.
REQ-018 At most one request SHALL be accepted per cycle; acceptance is req_valid[i] && req_ready[i].
REQ-019 req_ready SHALL be combinational from req_valid, state, and the round-robin pointer; it SHALL never assert for a requester with req_valid low.
REQ-020 An accepted request SHALL appear on out_addr/out_data/out_owner with out_valid=1 exactly one cycle after acceptance; out_valid SHALL be 0 otherwise.
REQ-021 out_addr/out_data/out_owner SHALL hold their last values while out_valid=0.
REQ-022 State machine SHALL have two states: IDLE and LOCKED.
REQ-023 In IDLE, grant SHALL go to the first requester with req_valid high, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
REQ-024 After any IDLE grant to requester g, rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-025 An IDLE grant with req_last=0 SHALL enter LOCKED with lock_owner=g and burst_cnt=1; with req_last=1 the arbiter SHALL stay in IDLE.
REQ-026 In LOCKED, only lock_owner SHALL be granted, and other requesters SHALL stall regardless of the pointer.
REQ-027 In LOCKED, each accept SHALL increment burst_cnt.
REQ-028 LOCKED SHALL return to IDLE on an accept with req_last=1, or on the accept that makes burst_cnt equal MAX_BURST (forced release).
REQ-029 On forced release, rr_ptr SHALL already point past the owner, so the owner must re-compete.
REQ-030 In LOCKED, an owner with req_valid low SHALL keep the lock; there SHALL be no timeout.
REQ-031 With MAX_BURST=1, every grant SHALL release the lock and LOCKED SHALL never be entered.
REQ-032 With NUM_REQ=1, requester 0 SHALL always win and the pointer SHALL remain 0.

Reset
REQ-033 Assertion of rst_n=0 SHALL immediately force: state=IDLE, rr_ptr=0, burst_cnt=0, out_valid=0, out_addr=0, out_data=0, out_owner=0, busy=0.
REQ-034 req_ready SHALL be all-zero while rst_n=0.
REQ-035 Reset during LOCKED SHALL abandon the burst, and no out_valid pulse SHALL follow reset for a pre-reset accept.
REQ-036 Deassertion SHALL be synchronized internally to clk with a 2-flop release.

Configuration
REQ-037 Macro CONFIG_ARB_STATS_EN, when defined, SHALL add output grant_count (NUM_REQ*32): per-requester accepted-write counters that saturate at 2^32-1 and reset to 0.
REQ-038 Without CONFIG_ARB_STATS_EN, the grant_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 NUM_REQ=2, both requesters' req_valid held with req_last=1 for 4 cycles -> grants alternate 0,1,0,1; out_owner sequence 0,1,0,1, each one cycle after its accept.
REQ-040 Requester 0 bursts 3 writes (req_last on the 3rd) while requester 1 is valid -> req_ready[1]=0 during the burst; requester 1 is granted in the cycle after the 3rd accept; busy is high for exactly 2 cycles.
REQ-041 MAX_BURST=4, requester 0 never asserts req_last, requester 1 valid -> after 4 accepts the lock is force-released and requester 1 is granted next.
REQ-042 Accept at addr=0x12, data=0xDEADBEEF -> next cycle out_valid=1, out_addr=0x12, out_data=0xDEADBEEF; the following cycle out_valid=0 with values held.
REQ-043 rst_n pulsed low mid-burst, in the cycle after an accept -> out_valid=0 immediately, busy=0, and after release requester 0 wins the first grant.
REQ-044 With CONFIG_ARB_STATS_EN, 5 accepts from requester 1 -> grant_count[1]=5, grant_count[0]=0; a counter preloaded to 0xFFFFFFFF stays at 0xFFFFFFFF on further accepts.

Source files
------------

// File: rtl/config_write_arbiter_if.sv
// Config-write request/response bundle between requesters and the config write arbiter.
// master: requester side; slave: arbiter side.
interface config_wr_if #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 64
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic                         out_valid;
    logic [ADDR_BITS-1:0]         out_addr;
    logic [DATA_BITS-1:0]         out_data;
    logic [OWN_W-1:0]             out_owner;
    logic                         busy;

    modport master (
        output req_valid, req_addr, req_data, req_last,
        input  req_ready, out_valid, out_addr, out_data, out_owner, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_last,
        output req_ready, out_valid, out_addr, out_data, out_owner, busy
    );
endinterface

// File: rtl/config_write_arbiter.sv
// Round-robin config-write arbiter with burst locking and forced release after MAX_BURST writes.
// Optional macro CONFIG_ARB_STATS_EN adds saturating per-requester grant counters (grant_count).
//
// state     | meaning
// ST_IDLE   | round-robin grant from rr_ptr among all valid requesters
// ST_LOCKED | only lock_owner may write until req_last or MAX_BURST writes
module config_write_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 64,
    parameter int MAX_BURST = 16
) (
    input  logic clk,
    input  logic rst_n,
    config_wr_if.slave bus
`ifdef CONFIG_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0] grant_count
`endif
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [OWN_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [OWN_W-1:0] lock_owner, lock_owner_nxt;
    logic [OWN_W-1:0] grant_idx, scan_idx;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt, cnt_inc;
    logic             grant_hit;
    logic             grant_last;
    logic [1:0]       rst_sync;
    logic             rst_sync_n;

    // Assert passes straight through; release takes two clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_sync_n = rst_sync[1];

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (state == ST_LOCKED) begin
            grant_idx = lock_owner;
            grant_hit = bus.req_valid[lock_owner];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan_idx = OWN_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (bus.req_valid[scan_idx]) begin
                    grant_hit = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (!rst_sync_n) begin
            grant_hit = 1'b0;
        end
    end

    assign grant_last    = bus.req_last[grant_idx];
    assign bus.req_ready = grant_hit ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.busy      = (state == ST_LOCKED);

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        lock_owner_nxt = lock_owner;
        burst_cnt_nxt  = burst_cnt;
        cnt_inc        = burst_cnt + CNT_W'(1);
        case (state)
            ST_IDLE: begin
                if (grant_hit) begin
                    rr_ptr_nxt = OWN_W'((int'(grant_idx) + 1) % NUM_REQ);
                    if (!grant_last && (MAX_BURST > 1)) begin
                        state_nxt      = ST_LOCKED;
                        lock_owner_nxt = grant_idx;
                        burst_cnt_nxt  = CNT_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (grant_hit) begin
                    if (grant_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
                        state_nxt     = ST_IDLE;
                        burst_cnt_nxt = '0;
                    end else begin
                        burst_cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            lock_owner <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock_owner <= lock_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // Output bus has no backpressure: one strobe per accept, payload held otherwise.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_owner <= '0;
        end else begin
            bus.out_valid <= grant_hit;
            if (grant_hit) begin
                bus.out_addr  <= bus.req_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
                bus.out_data  <= bus.req_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
                bus.out_owner <= grant_idx;
            end
        end
    end

`ifdef CONFIG_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            grant_count <= '0;
        end else if (grant_hit &&
                     (grant_count[int'(grant_idx)*32 +: 32] != 32'hFFFF_FFFF)) begin
            grant_count[int'(grant_idx)*32 +: 32] <=
                grant_count[int'(grant_idx)*32 +: 32] + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_config_write_arbiter.sv
// Table-driven bench for config_write_arbiter: per-cycle grant/busy vectors plus an output scoreboard.
module tb_config_write_arbiter;
    localparam int NR = 2;
    localparam int AB = 8;
    localparam int DB = 64;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    config_wr_if #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

`ifdef CONFIG_ARB_STATS_EN
    logic [NR*32-1:0] grant_count;
    int               acc_cnt [NR];
`endif

    config_write_arbiter #(
        .NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB), .MAX_BURST(MB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CONFIG_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] last;
        logic [1:0] exp_ready;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        logic [0:0]    owner;
    } exp_t;

    vec_t          vt [$];
    exp_t          sb [$];
    exp_t          last_out;
    logic [AB-1:0] cur_addr [NR];
    logic [DB-1:0] cur_data [NR];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] v, input logic [1:0] l, input logic [1:0] r, input logic b);
        vec_t x;
        x.valid     = v;
        x.last      = l;
        x.exp_ready = r;
        x.exp_busy  = b;
        vt.push_back(x);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid", 64'(bus.out_valid), 64'd1);
            chk("out_addr", 64'(bus.out_addr), 64'(e.addr));
            chk("out_data", bus.out_data, e.data);
            chk("out_owner", 64'(bus.out_owner), 64'(e.owner));
            last_out = e;
        end else begin
            chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
            chk("out_addr_hold", 64'(bus.out_addr), 64'(last_out.addr));
            chk("out_data_hold", bus.out_data, last_out.data);
            chk("out_owner_hold", 64'(bus.out_owner), 64'(last_out.owner));
        end
    endtask

    // One clock cycle: drive at negedge, check ready/busy mid-cycle, check outputs after the edge.
    task automatic step(input logic [1:0] v, input logic [1:0] l, input logic [1:0] er, input logic eb);
        exp_t e;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_last  = l;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AB +: AB] = cur_addr[i];
            bus.req_data[i*DB +: DB] = cur_data[i];
        end
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("busy", 64'(bus.busy), 64'(eb));
        for (int i = 0; i < NR; i++) begin
            if (er[i]) begin
                e.addr  = cur_addr[i];
                e.data  = cur_data[i];
                e.owner = 1'(i);
                sb.push_back(e);
`ifdef CONFIG_ARB_STATS_EN
                acc_cnt[i]++;
`endif
            end
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_last  = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_owner", 64'(bus.out_owner), 64'd0);
        sb.delete();
        last_out.addr  = '0;
        last_out.data  = '0;
        last_out.owner = '0;
`ifdef CONFIG_ARB_STATS_EN
        for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready_hold", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        // Two-flop release: still no grant one edge after deassertion.
        step(2'b11, 2'b11, 2'b00, 1'b0);
    endtask

    task automatic randomize_payload();
        for (int i = 0; i < NR; i++) begin
            cur_addr[i] = 8'($urandom);
            cur_data[i] = {$urandom, $urandom};
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        randomize_payload();

        // alternating grants
        add(2'b11, 2'b11, 2'b01, 1'b0);
        add(2'b11, 2'b11, 2'b10, 1'b0);
        add(2'b11, 2'b11, 2'b01, 1'b0);
        add(2'b11, 2'b11, 2'b10, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0);
        // 3-write burst from requester 0 with requester 1 waiting
        add(2'b11, 2'b00, 2'b01, 1'b0);
        add(2'b11, 2'b00, 2'b01, 1'b1);
        add(2'b11, 2'b01, 2'b01, 1'b1);
        add(2'b10, 2'b10, 2'b10, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0);
        // owner drops valid mid-burst and keeps the lock
        add(2'b01, 2'b00, 2'b01, 1'b0);
        add(2'b10, 2'b00, 2'b00, 1'b1);
        add(2'b10, 2'b00, 2'b00, 1'b1);
        add(2'b11, 2'b01, 2'b01, 1'b1);
        add(2'b10, 2'b10, 2'b10, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0);
        // forced release after MAX_BURST=4 writes
        add(2'b11, 2'b00, 2'b01, 1'b0);
        add(2'b11, 2'b00, 2'b01, 1'b1);
        add(2'b11, 2'b00, 2'b01, 1'b1);
        add(2'b11, 2'b00, 2'b01, 1'b1);
        add(2'b11, 2'b00, 2'b10, 1'b0);
        add(2'b11, 2'b10, 2'b10, 1'b1);
        add(2'b00, 2'b00, 2'b00, 1'b0);
        // pointer wrap-around with single requesters
        add(2'b10, 2'b10, 2'b10, 1'b0);
        add(2'b01, 2'b01, 2'b01, 1'b0);
        add(2'b01, 2'b01, 2'b01, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0);

        do_reset();
        for (int k = 0; k < vt.size(); k++) begin
            randomize_payload();
            step(vt[k].valid, vt[k].last, vt[k].exp_ready, vt[k].exp_busy);
        end

        // exact payload then hold
        cur_addr[0] = 8'h12;
        cur_data[0] = 64'h0000_0000_DEAD_BEEF;
        step(2'b01, 2'b01, 2'b01, 1'b0);
        randomize_payload();
        step(2'b00, 2'b00, 2'b00, 1'b0);

        // reset in the cycle after a burst-opening accept (pointer is 1 beforehand)
        step(2'b01, 2'b00, 2'b01, 1'b0);
        do_reset();
        step(2'b11, 2'b11, 2'b01, 1'b0);
        step(2'b00, 2'b00, 2'b00, 1'b0);

        // five single writes from requester 1
        for (int k = 0; k < 5; k++) begin
            randomize_payload();
            step(2'b10, 2'b10, 2'b10, 1'b0);
        end
        step(2'b00, 2'b00, 2'b00, 1'b0);

`ifdef CONFIG_ARB_STATS_EN
        for (int i = 0; i < NR; i++) begin
            chk("grant_count", 64'(grant_count[i*32 +: 32]), 64'(acc_cnt[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
